// File: rtl/program_loader_pkg.sv
// Shared types and default sizes for the program memory path
// (program counter, program memory and the loader).
package program_loader_pkg;

  localparam int PROG_ADDR_W = 5;
  localparam int PROG_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Streams instruction words into program memory from address 0 while holding
// the CPU in reset; reports length, XOR checksum and overflow of the session.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int DATA_W = PROG_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   load_len,
  output logic [DATA_W-1:0] checksum
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              accept, at_max, clear;

  assign in_ready = (state == S_LOAD);
  assign done     = (state == S_DONE);
  assign accept   = in_valid && in_ready;
  assign at_max   = (addr == {ADDR_W{1'b1}});
  assign clear    = start && (state != S_LOAD);
  // CPU stays held until the final registered write has left the loader
  assign cpu_hold = in_ready || mem_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (accept && (in_last || at_max)) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      addr      <= '0;
      load_len  <= '0;
      checksum  <= '0;
      overflow  <= 1'b0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= addr;
        mem_wdata <= in_data;
      end
      if (clear) begin
        addr     <= '0;
        load_len <= '0;
        checksum <= '0;
        overflow <= 1'b0;
      end else if (accept) begin
        // terminal count ends the session, so the counter never wraps to 0
        if (!at_max) addr <= addr + ADDR_W'(1);
        load_len <= load_len + (ADDR_W+1)'(1);
        checksum <= checksum ^ in_data;
        overflow <= at_max && !in_last;
      end
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Writer-side counterpart to the program counter. The program counter reads program memory; this block fills it.
- Accepts a stream of instruction words over a valid/ready handshake.
- Writes them into program memory at sequential addresses starting at 0.
- Holds the CPU in reset while loading.
- Reports the loaded length, an XOR checksum and an overflow flag when the memory fills before the stream ends.

Parameters:
ADDR_W, 5, program memory address width; capacity 2**ADDR_W words
DATA_W, 8, instruction word width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  single-cycle pulse; begins a load session
in_valid  input  1  in_data/in_last valid
in_data  input  DATA_W  instruction word
in_last  input  1  marks final word of program
in_ready  output  1  loader can accept a word this cycle
mem_we  output  1  program memory write strobe
mem_addr  output  ADDR_W  program memory write address
mem_wdata  output  DATA_W  program memory write data
cpu_hold  output  1  keeps the CPU/program counter in reset while high
done  output  1  load session finished (level, until next start or rst)
overflow  output  1  memory filled before in_last was seen
load_len  output  ADDR_W+1  number of words written in the last session
checksum  output  DATA_W  XOR of all words written in the last session

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs are 0; internal address counter is 0. Program memory contents are not cleared.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0, done=0.
  - start -> LOAD on the next edge. The same edge clears the address counter, load_len, checksum and overflow.
- LOAD:
  - in_ready=1, decoded combinationally from state.
  - A word is accepted on a clock edge where in_valid && in_ready.
  - Start pulses are ignored.
- Accept at address A:
  - Next cycle: mem_we=1, mem_addr=A, mem_wdata=word. This is a registered write with 1-cycle latency.
  - Same edge: load_len+=1, checksum^=word, address counter = A+1.
  - mem_we is 0 in every cycle not following an accept. Back-to-back accepts produce back-to-back writes.
- Accept with in_last=1: -> DONE, overflow=0.
- Accept at A=2**ADDR_W-1 with in_last=0:
  - -> DONE, overflow=1.
  - The word is still written. The counter does not wrap into address 0.
- Accept at max address with in_last=1: -> DONE, overflow=0 (exact fit).
- DONE:
  - in_ready=0, done=1.
  - load_len/checksum/overflow hold their values.
  - start -> LOAD, clearing them as in IDLE.
- cpu_hold = (state==LOAD) || mem_we. The CPU is released only after the final write strobe. The first cycle with done=1 therefore still has cpu_hold=1.
- in_valid without in_ready (IDLE/DONE): data ignored, no write, no counter change.
- start and in_valid in the same IDLE cycle: only start acts; the word is not accepted.
- rst mid-LOAD:
  - Immediately IDLE, outputs 0, mem_we drops asynchronously.
  - Words already written remain in memory; done stays 0.
- load_len range is 0..2**ADDR_W. It is ADDR_W+1 bits wide so a full memory is representable.

Decomposition:
- Shared package holds:
  - the state typedef (IDLE, LOAD, DONE);
  - localparams for the default ADDR_W/DATA_W, shared with the program counter and program memory.
- No sub-module is required. The address counter is a small inline counter with a terminal-count compare at 2**ADDR_W-1, mirroring the program counter's max detection.

Test Plan:
- rst=1 with outputs toggled, release -> all outputs 0, state IDLE; in_valid=1 in IDLE gives no mem_we.
- start, then 3 words 0x12,0x34,0x56 (last on 0x56), back-to-back:
  - mem_we on 3 consecutive cycles: addr 0/1/2, data 0x12/0x34/0x56;
  - done=1, load_len=3, checksum=0x70, overflow=0;
  - cpu_hold falls one cycle after the third accept.
- Same stream with in_valid gaps of 2 idle cycles -> identical writes at addr 0,1,2; mem_we is never high in gap cycles.
- ADDR_W=5, 33 words with in_last never set:
  - 32 writes at addr 0..31, then DONE with overflow=1, load_len=32;
  - 33rd word sees in_ready=0 and addr 0 is never rewritten.
- 32 words with in_last on word 32 -> overflow=0, load_len=32, done=1.
- rst pulsed after 2 accepts of a 5-word load -> mem_we drops the same cycle, done=0, cpu_hold=0. A new start reloads from addr 0 with load_len counting from 0.
